// File: rtl/mac_fifo_loader_if.sv
`default_nettype none
// ============================================================================
// mac_fifo_loader_if : row-memory read port plus shared FIFO write bus
// Revision: 1.0
// ============================================================================
interface mac_fifo_loader_if #(
  parameter int NUM_A  = 8,
  parameter int BYTES  = 8,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]  mem_address;
  logic               mem_read;
  logic               mem_waitrequest;
  logic [8*BYTES-1:0] mem_readdata;
  logic               mem_readdatavalid;
  logic [7:0]         fifo_data;
  logic [NUM_A-1:0]   wren_a;
  logic               wren_b;
  logic [NUM_A-1:0]   full_a;
  logic               full_b;

  modport master (
    output mem_address, mem_read,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
    output fifo_data, wren_a, wren_b,
    input  full_a, full_b
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  fifo_data, wren_a, wren_b,
    output full_a, full_b
  );
endinterface
`default_nettype wire

// File: rtl/mac_fifo_loader.sv
`default_nettype none
// ============================================================================
// mac_fifo_loader : reads B row then A rows 0..NUM_A-1, byte-serialises each
//                   word (LSB first) into the matching 8-bit FIFO
// Revision: 1.0
// ============================================================================
module mac_fifo_loader #(
  parameter int NUM_A     = 8,
  parameter int BYTES     = 8,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  mac_fifo_loader_if.master bus,
  output logic              busy,
  output logic              done
);
  localparam int ROW_W = $clog2(NUM_A + 1);
  localparam int COL_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_A);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAITDATA = 3'd2,
    S_PUSH     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [8*BYTES-1:0] r_word;

  logic [NUM_A-1:0]   w_sel_a;
  logic               w_is_b;
  logic               w_full;
  logic               w_push;

  // Row 0 targets B; row k targets A[k-1], so w_sel_a is all-zero on row 0.
  always_comb begin
    w_sel_a = '0;
    for (int i = 0; i < NUM_A; i++) begin
      w_sel_a[i] = (r_row == ROW_W'(i + 1));
    end
  end

  assign w_is_b = (r_row == '0);
  assign w_full = w_is_b ? bus.full_b : |(bus.full_a & w_sel_a);
  assign w_push = (r_state == S_PUSH) && !w_full;

  assign bus.wren_b      = w_push && w_is_b;
  assign bus.wren_a      = w_push ? w_sel_a : '0;
  assign bus.fifo_data   = (r_state == S_PUSH) ? r_word[{r_col, 3'b000} +: 8] : 8'h00;
  assign bus.mem_read    = (r_state == S_REQ);
  assign bus.mem_address = ADDR_W'(BASE_ADDR) + ADDR_W'(r_row);

  assign busy = (r_state == S_REQ) || (r_state == S_WAITDATA) || (r_state == S_PUSH);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_REQ;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_REQ: begin
          if (!bus.mem_waitrequest) begin
            r_state <= S_WAITDATA;
          end
        end
        S_WAITDATA: begin
          if (bus.mem_readdatavalid) begin
            r_word  <= bus.mem_readdata;
            r_col   <= '0;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          // A full target stalls with col held so no byte is dropped.
          if (!w_full) begin
            if (r_col == LAST_COL) begin
              r_col <= '0;
              if (r_row == LAST_ROW) begin
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= S_REQ;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/mac_fifo_loader.md
Name: mac_fifo_loader

Overview:
- Sequencer that fills the MAC input FIFOs from the 64-bit row memory (mem_wrapper Avalon-style read port).
- Issues one row read per memory word: the B vector row first, then A rows 0..7.
- Serialises each 64-bit word into eight 8-bit FIFO writes, LSB byte first.
- Sits between mem_wrapper and the nine 8-bit FIFOs (fifo instances A_fifo[0..7], B_fifo); the MAC array consumes the FIFOs downstream.

Parameters:
- NUM_A, 8, number of A row FIFOs (one row per FIFO)
- BYTES, 8, bytes per memory word (word width = 8*BYTES)
- ADDR_W, 32, memory address width
- BASE_ADDR, 0, word address of B row; A row r lives at BASE_ADDR+1+r

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a load sequence
- mem_address  out  ADDR_W  row word address
- mem_read  out  1  read request
- mem_waitrequest  in  1  memory busy; request held while high
- mem_readdata  in  8*BYTES  returned row word
- mem_readdatavalid  in  1  mem_readdata valid this cycle
- fifo_data  out  8  byte to all FIFO data inputs (shared bus)
- wren_a  out  NUM_A  one-hot write enable, A FIFOs
- wren_b  out  1  write enable, B FIFO
- full_a  in  NUM_A  A FIFO wrfull flags
- full_b  in  1  B FIFO wrfull flag
- busy  out  1  sequence in progress
- done  out  1  all rows loaded

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Reset (including mid-operation) forces IDLE, row=0, col=0, word register=0.
- Outputs during reset: mem_read=0, mem_address=BASE_ADDR, wren_a=0, wren_b=0, fifo_data=0, busy=0, done=0.
- States: IDLE, REQ, WAITDATA, PUSH, DONE. row counter 0..NUM_A (0=B, k=A[k-1]); col counter 0..BYTES-1.
- IDLE: start=1 -> REQ, row=0.
- REQ:
  - mem_read=1, mem_address=BASE_ADDR+row.
  - Held while mem_waitrequest=1.
  - Request accepted on mem_read & !mem_waitrequest -> WAITDATA.
- WAITDATA:
  - mem_read=0; one outstanding read only.
  - On mem_readdatavalid, capture mem_readdata into the word register, col=0 -> PUSH.
- PUSH:
  - Target FIFO is B when row=0, else A[row-1].
  - If target not full: the target's enable is 1 this cycle, fifo_data=word[8*col +: 8], col++.
  - If target full: all enables 0, col holds (stall, no data lost).
  - Write enables and fifo_data are combinational from state/row/col/word; the FIFO samples on the next clk edge.
  - After the write with col=BYTES-1: if row=NUM_A -> DONE, else row++ -> REQ.
- DONE: done=1 (level), busy=0. start -> REQ with row=0, a fresh load.
- busy=1 in REQ, WAITDATA, PUSH.
- start outside IDLE/DONE is ignored.
- mem_readdatavalid outside WAITDATA is ignored.
- At most one wren bit (wren_a or wren_b) is asserted in any cycle.
- Minimum latency per row with waitrequest=0 and one-cycle read latency: REQ 1 + WAITDATA 1 + PUSH 8 = 10 cycles. Full sequence: 90 cycles from the first REQ cycle to DONE entry.

Test Plan:
1. Reset, then start; memory has zero wait and 1-cycle latency; word at addr 0 = 64'h0807060504030201 -> wren_b pulses 8 consecutive cycles, fifo_data 01,02,...,08; then mem_read with address 1.
2. Full run with A row r word = {8{8'h10+r}} -> each wren_a[r] asserts exactly 8 times with byte 10+r; no two enables ever overlap; done=1 exactly 90 cycles after first REQ.
3. mem_waitrequest held high 5 cycles in REQ -> mem_read and mem_address stable throughout; no duplicate request; WAITDATA entered on the first low cycle.
4. full_a[2] high for 4 cycles mid-row 3 at col=5 -> wren_a[2]=0 during stall; on release, bytes 5..7 written in order; total writes for that row = 8.
5. rst_n low during PUSH of row 4 -> outputs zero immediately (asynchronous); after release, stays in IDLE until start; a new start re-reads address 0.
6. Spurious mem_readdatavalid in IDLE, and start pulsed during PUSH -> no writes, no restart; sequence completes normally with done=1.
